// File: rtl/priority_encoder_seq_if.sv
// Request/response channel of priority_encoder_seq: request vector in, encoded index out.
interface priority_encoder_seq_if #(
  parameter int N = 3
);
  localparam int W = 1 << N;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req;
  logic         y_valid;
  logic         y_ready;
  logic [N-1:0] y;
  logic         busy;

  modport slave (
    input  req_valid, req, y_ready,
    output req_ready, y_valid, y, busy
  );

  modport master (
    output req_valid, req, y_ready,
    input  req_ready, y_valid, y, busy
  );
endinterface

// File: rtl/priority_encoder_seq.sv
// Sequential multi-hot to binary encoder: stores a 2**N-bit vector and emits one set-bit index per transfer.
// Optional macro ROUND_ROBIN_EN: round-robin selection starting after the last issued index (default: lowest index first).
module priority_encoder_seq #(
  parameter int N = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  priority_encoder_seq_if.slave bus
);
  localparam int W = 1 << N;

  logic [W-1:0] pending_q, pending_d;
  logic [N-1:0] y_q, y_d;
  logic         y_valid_q, y_valid_d;
  logic         slot_free, load, issue;
  logic [N-1:0] sel;

  function automatic logic [N-1:0] lowest_set(input logic [W-1:0] v);
    logic [N-1:0] idx;
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) idx = N'(i);
    end
    return idx;
  endfunction

`ifdef ROUND_ROBIN_EN
  logic [N-1:0] ptr_q, ptr_d;

  // Search ptr+1 .. ptr+W (mod W); iterating farthest-first lets the nearest hit win.
  function automatic logic [N-1:0] rr_select(input logic [W-1:0] v, input logic [N-1:0] ptr);
    logic [N-1:0] idx, j;
    idx = '0;
    for (int k = W; k >= 1; k--) begin
      j = ptr + N'(k);
      if (v[j]) idx = j;
    end
    return idx;
  endfunction
`endif

  always_comb begin
    slot_free = !y_valid_q || bus.y_ready;
    load      = bus.req_valid && (pending_q == '0);
    issue     = (pending_q != '0) && slot_free;
`ifdef ROUND_ROBIN_EN
    sel       = rr_select(pending_q, ptr_q);
    ptr_d     = ptr_q;
    if (issue) ptr_d = sel;
`else
    sel       = lowest_set(pending_q);
`endif
    pending_d = pending_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    // load requires pending == 0 and issue requires pending != 0, so they never overlap
    if (load) pending_d = bus.req;
    if (issue) begin
      pending_d[sel] = 1'b0;
      y_d            = sel;
      y_valid_d      = 1'b1;
    end else if (slot_free) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr_q     <= '1;
`endif
    end else begin
      pending_q <= pending_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
`ifdef ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.req_ready = (pending_q == '0);
  assign bus.y         = y_q;
  assign bus.y_valid   = y_valid_q;
  assign bus.busy      = (pending_q != '0) || y_valid_q;
endmodule
